// File: rtl/riscv_regfile_sb.sv
// RV32I integer register file with per-register busy scoreboard and optional write-to-read bypass.
// Latency: reads combinational, write lands one edge later (zero with BYPASS), pending_cnt_o registered.
// Backpressure: none consumed; stall_o tells decode to hold when an enabled operand is still pending.
module riscv_regfile_sb #(
    parameter int DATA_WIDTH   = 32,
    parameter int REG_ADDR     = 5,
    parameter int REG_COUNT    = 32,
    parameter int NUM_RD_PORTS = 2,
    parameter int BYPASS       = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_RD_PORTS*REG_ADDR-1:0]   rd_addr_i,
    input  logic [NUM_RD_PORTS-1:0]            rd_en_i,
    output logic [NUM_RD_PORTS*DATA_WIDTH-1:0] rd_data_o,
    output logic [NUM_RD_PORTS-1:0]            rd_busy_o,
    output logic                               stall_o,
    input  logic                               wr_en_i,
    input  logic [REG_ADDR-1:0]                wr_addr_i,
    input  logic [DATA_WIDTH-1:0]              wr_data_i,
    input  logic                               sb_set_i,
    input  logic [REG_ADDR-1:0]                sb_addr_i,
    input  logic                               flush_i,
    output logic [REG_ADDR:0]                  pending_cnt_o
);

    // x0 is hardwired, so storage and busy state start at index 1.
    logic [DATA_WIDTH-1:0] regs_q [1:REG_COUNT-1];
    logic [REG_COUNT-1:1]  busy_q;
    logic [REG_COUNT-1:1]  busy_d;
    logic [REG_ADDR:0]     cnt_q;
    logic [REG_ADDR:0]     cnt_d;
    logic                  wr_live;
    logic [REG_ADDR-1:0]   ra;
    logic                  fwd;

    assign wr_live = wr_en_i && (wr_addr_i != '0);

    // A new producer issuing to a register supersedes the writeback completing on it.
    always_comb begin
        busy_d = busy_q;
        if (flush_i) begin
            busy_d = '0;
        end else begin
            for (int r = 1; r < REG_COUNT; r++) begin
                if (sb_set_i && (sb_addr_i == REG_ADDR'(r))) begin
                    busy_d[r] = 1'b1;
                end else if (wr_en_i && (wr_addr_i == REG_ADDR'(r))) begin
                    busy_d[r] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        cnt_d = '0;
        for (int r = 1; r < REG_COUNT; r++) begin
            cnt_d = cnt_d + (REG_ADDR+1)'(busy_d[r]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
            cnt_q  <= '0;
            for (int r = 1; r < REG_COUNT; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            if (wr_live) begin
                regs_q[wr_addr_i] <= wr_data_i;
            end
        end
    end

    always_comb begin
        rd_data_o = '0;
        rd_busy_o = '0;
        ra        = '0;
        fwd       = 1'b0;
        for (int p = 0; p < NUM_RD_PORTS; p++) begin
            ra  = rd_addr_i[p*REG_ADDR +: REG_ADDR];
            fwd = (BYPASS != 0) && wr_en_i && (wr_addr_i == ra);
            if (ra != '0) begin
                rd_data_o[p*DATA_WIDTH +: DATA_WIDTH] = fwd ? wr_data_i : regs_q[ra];
                rd_busy_o[p] = busy_q[ra] && !fwd;
            end
        end
    end

    assign stall_o       = |(rd_en_i & rd_busy_o);
    assign pending_cnt_o = cnt_q;

endmodule
